// File: rtl/enemy_fire_scheduler.sv
// Per-frame enemy fire scheduler: threshold/cooldown request, round-robin grant into a bullet-slot pool.
// Optional ENEMY_FIRE_STATS_EN adds saturating shots_fired_o / shots_dropped_o counters.
module enemy_fire_scheduler #(
    parameter int NUM_SLOTS       = 4,
    parameter int SLOT_W          = 2,
    parameter int CD_W            = 8,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic                 frame_clk_i,
    input  logic                 rst_n_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [5:0]           fire_threshold_i,
    input  logic [3:0]           enemy_alive_i,
    input  logic [5:0]           enemy_shoot1_i,
    input  logic [5:0]           enemy_shoot2_i,
    input  logic [5:0]           enemy_shoot3_i,
    input  logic [5:0]           enemy_shoot4_i,
    input  logic [NUM_SLOTS-1:0] slot_free_i,
`ifdef ENEMY_FIRE_STATS_EN
    output logic [15:0]          shots_fired_o,
    output logic [15:0]          shots_dropped_o,
`endif
    output logic                 spawn_valid_o,
    output logic [1:0]           spawn_enemy_o,
    output logic [SLOT_W-1:0]    spawn_slot_o,
    output logic [NUM_SLOTS-1:0] slots_busy_o,
    output logic [3:0]           cooldown_active_o
);

    logic [CD_W-1:0]      cd_q [4];
    logic [CD_W-1:0]      cd_d [4];
    logic [1:0]           rr_q, rr_d;
    logic [NUM_SLOTS-1:0] busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [1:0]           enemy_q, enemy_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [3:0]           cd_act_q, cd_act_d;

    logic [5:0]           shoot [4];
    logic [3:0]           req;
    logic                 found;
    logic [1:0]           winner;
    logic [1:0]           idx;
    logic                 slot_ok;
    logic [SLOT_W-1:0]    slot_sel;
    logic                 grant;

    assign shoot[0] = enemy_shoot1_i;
    assign shoot[1] = enemy_shoot2_i;
    assign shoot[2] = enemy_shoot3_i;
    assign shoot[3] = enemy_shoot4_i;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req[i] = enemy_alive_i[i] && (shoot[i] < fire_threshold_i) && (cd_q[i] == '0);
        end

        found  = 1'b0;
        winner = rr_q;
        idx    = rr_q;
        for (int k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end

        // Descending scan so the lowest idle slot is the one left selected.
        slot_ok  = 1'b0;
        slot_sel = '0;
        for (int j = NUM_SLOTS - 1; j >= 0; j--) begin
            if (!busy_q[j]) begin
                slot_ok  = 1'b1;
                slot_sel = SLOT_W'(j);
            end
        end

        grant = enable_i && found && slot_ok;
    end

    always_comb begin
        rr_d    = rr_q;
        enemy_d = enemy_q;
        slot_d  = slot_q;
        valid_d = 1'b0;
        busy_d  = busy_q & ~slot_free_i;
        for (int i = 0; i < 4; i++) begin
            cd_d[i] = cd_q[i];
        end

        if (enable_i) begin
            for (int i = 0; i < 4; i++) begin
                if (cd_q[i] != '0) begin
                    cd_d[i] = cd_q[i] - 1'b1;
                end
            end
            if (grant) begin
                valid_d          = 1'b1;
                enemy_d          = winner;
                slot_d           = slot_sel;
                busy_d[slot_sel] = 1'b1;
                cd_d[winner]     = CD_W'(COOLDOWN_FRAMES);
                rr_d             = winner + 2'd1;
            end
        end

        for (int i = 0; i < 4; i++) begin
            cd_act_d[i] = (cd_d[i] != '0);
        end
    end

    always_ff @(posedge frame_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_q     <= '0;
            busy_q   <= '0;
            valid_q  <= 1'b0;
            enemy_q  <= '0;
            slot_q   <= '0;
            cd_act_q <= '0;
            for (int i = 0; i < 4; i++) cd_q[i] <= '0;
        end else if (clear_i) begin
            rr_q     <= '0;
            busy_q   <= '0;
            valid_q  <= 1'b0;
            enemy_q  <= '0;
            slot_q   <= '0;
            cd_act_q <= '0;
            for (int i = 0; i < 4; i++) cd_q[i] <= '0;
        end else begin
            rr_q     <= rr_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            enemy_q  <= enemy_d;
            slot_q   <= slot_d;
            cd_act_q <= cd_act_d;
            for (int i = 0; i < 4; i++) cd_q[i] <= cd_d[i];
        end
    end

    assign spawn_valid_o     = valid_q;
    assign spawn_enemy_o     = enemy_q;
    assign spawn_slot_o      = slot_q;
    assign slots_busy_o      = busy_q;
    assign cooldown_active_o = cd_act_q;

`ifdef ENEMY_FIRE_STATS_EN
    logic [15:0] fired_q, dropped_q;
    logic        drop;

    assign drop = enable_i && found && !slot_ok;

    always_ff @(posedge frame_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fired_q   <= '0;
            dropped_q <= '0;
        end else if (clear_i) begin
            fired_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (grant && fired_q != 16'hFFFF) fired_q <= fired_q + 16'd1;
            if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
        end
    end

    assign shots_fired_o   = fired_q;
    assign shots_dropped_o = dropped_q;
`endif

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed scoreboard bench for enemy_fire_scheduler (default parameters).
module tb_enemy_fire_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       enable;
    logic [5:0] thr;
    logic [3:0] alive;
    logic [5:0] sh1, sh2, sh3, sh4;
    logic [3:0] slot_free;
    logic       spawn_valid;
    logic [1:0] spawn_enemy;
    logic [1:0] spawn_slot;
    logic [3:0] slots_busy;
    logic [3:0] cd_active;
`ifdef ENEMY_FIRE_STATS_EN
    logic [15:0] shots_fired, shots_dropped;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       v;
        logic [1:0] e;
        logic [1:0] s;
        logic [3:0] b;
        logic [3:0] c;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    enemy_fire_scheduler dut (
        .frame_clk_i       (clk),
        .rst_n_i           (rst_n),
        .clear_i           (clear),
        .enable_i          (enable),
        .fire_threshold_i  (thr),
        .enemy_alive_i     (alive),
        .enemy_shoot1_i    (sh1),
        .enemy_shoot2_i    (sh2),
        .enemy_shoot3_i    (sh3),
        .enemy_shoot4_i    (sh4),
        .slot_free_i       (slot_free),
`ifdef ENEMY_FIRE_STATS_EN
        .shots_fired_o     (shots_fired),
        .shots_dropped_o   (shots_dropped),
`endif
        .spawn_valid_o     (spawn_valid),
        .spawn_enemy_o     (spawn_enemy),
        .spawn_slot_o      (spawn_slot),
        .slots_busy_o      (slots_busy),
        .cooldown_active_o (cd_active)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Push the expected post-edge outputs, clock once, then pop and compare.
    task automatic step(input string tag, input logic v, input logic [1:0] e,
                        input logic [1:0] s, input logic [3:0] b, input logic [3:0] c);
        exp_t x;
        exp_t y;
        x.v = v; x.e = e; x.s = s; x.b = b; x.c = c;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            y = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, spawn_valid}, {31'd0, y.v});
            if (y.v) begin
                chk({tag, "_enemy"}, {30'd0, spawn_enemy}, {30'd0, y.e});
                chk({tag, "_slot"}, {30'd0, spawn_slot}, {30'd0, y.s});
            end
            chk({tag, "_busy"}, {28'd0, slots_busy}, {28'd0, y.b});
            chk({tag, "_cdact"}, {28'd0, cd_active}, {28'd0, y.c});
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; enable = 1'b0; thr = 6'd0; alive = 4'b0;
        sh1 = 6'd0; sh2 = 6'd0; sh3 = 6'd0; sh4 = 6'd0; slot_free = 4'b0;

        #2;
        chk("reset_valid", {31'd0, spawn_valid}, 32'd0);
        chk("reset_busy", {28'd0, slots_busy}, 32'd0);
        chk("reset_cdact", {28'd0, cd_active}, 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1; enable = 1'b1; thr = 6'd63; alive = 4'b1111;

        // Fill all four slots in round-robin order.
        step("fill0", 1'b1, 2'd0, 2'd0, 4'b0001, 4'b0001);
        step("fill1", 1'b1, 2'd1, 2'd1, 4'b0011, 4'b0011);
        step("fill2", 1'b1, 2'd2, 2'd2, 4'b0111, 4'b0111);
        step("fill3", 1'b1, 2'd3, 2'd3, 4'b1111, 4'b1111);

        // Cooldowns drain one by one; later requests find every slot busy.
        for (int n = 5; n <= 34; n++) begin
            step("full", 1'b0, 2'd0, 2'd0, 4'b1111,
                 {(n < 34), (n < 33), (n < 32), (n < 31)});
        end

        slot_free = 4'b0100;
        step("free_edge", 1'b0, 2'd0, 2'd0, 4'b1011, 4'b0000);
        slot_free = 4'b0000;
        step("reuse", 1'b1, 2'd0, 2'd2, 4'b1111, 4'b0001);

        clear = 1'b1;
        step("clear", 1'b0, 2'd0, 2'd0, 4'b0000, 4'b0000);
        clear = 1'b0;

        // Strict less-than: 10 is not below 10, 9 is.
        thr = 6'd10; sh1 = 6'd10; sh2 = 6'd9; sh3 = 6'd63; sh4 = 6'd63;
        step("thr_grant", 1'b1, 2'd1, 2'd0, 4'b0001, 4'b0010);
        step("thr_pulse", 1'b0, 2'd0, 2'd0, 4'b0001, 4'b0010);

        clear = 1'b1;
        step("clear2", 1'b0, 2'd0, 2'd0, 4'b0000, 4'b0000);
        clear = 1'b0;

        thr = 6'd63; alive = 4'b0001; sh1 = 6'd0; sh2 = 6'd0; sh3 = 6'd0; sh4 = 6'd0;
        step("cd_first", 1'b1, 2'd0, 2'd0, 4'b0001, 4'b0001);
        for (int n = 42; n <= 71; n++) begin
            step("cd_wait", 1'b0, 2'd0, 2'd0, 4'b0001, {3'b000, (n <= 70)});
        end
        step("cd_regrant", 1'b1, 2'd0, 2'd1, 4'b0011, 4'b0001);

        // Run cooldown down to 12, then pause for five frames.
        for (int n = 73; n <= 90; n++) begin
            step("pre_pause", 1'b0, 2'd0, 2'd0, 4'b0011, 4'b0001);
        end
        enable = 1'b0;
        step("pause0", 1'b0, 2'd0, 2'd0, 4'b0011, 4'b0001);
        slot_free = 4'b1001;
        step("pause_free", 1'b0, 2'd0, 2'd0, 4'b0010, 4'b0001);
        slot_free = 4'b0000;
        for (int n = 93; n <= 95; n++) begin
            step("pause", 1'b0, 2'd0, 2'd0, 4'b0010, 4'b0001);
        end
        enable = 1'b1;
        for (int n = 96; n <= 107; n++) begin
            step("resume", 1'b0, 2'd0, 2'd0, 4'b0010, {3'b000, (n <= 106)});
        end
        step("resume_grant", 1'b1, 2'd0, 2'd0, 4'b0011, 4'b0001);

`ifdef ENEMY_FIRE_STATS_EN
        chk("stats_fired", {16'd0, shots_fired}, 32'd3);
        chk("stats_dropped", {16'd0, shots_dropped}, 32'd0);
`endif

        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, spawn_valid}, 32'd0);
        chk("async_busy", {28'd0, slots_busy}, 32'd0);
        chk("async_cdact", {28'd0, cd_active}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
